// File: rtl/sys_defs.sv
// Shared machine-wide definitions: superscalar width, RS allocate packet and
// dispatch-queue sizing types.
`ifndef DQ_DEPTH
`define DQ_DEPTH 8
`endif

package sys_defs;

  localparam int SYS_WAYS = 3;
  localparam int XLEN     = 32;
  localparam int PRN_W    = 6;

  typedef logic [$clog2(`DQ_DEPTH)-1:0] DQ_IDX;
  typedef logic [$clog2(`DQ_DEPTH):0]   DQ_CNT;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  inst;
    logic [XLEN-1:0]  npc;
    logic [PRN_W-1:0] dest_prn;
    logic [PRN_W-1:0] src1_prn;
    logic [PRN_W-1:0] src2_prn;
  } RS_IN_PACKET;

endpackage

// File: rtl/dq_lane_select.sv
// In-order lane grant: lane 2 is oldest, and a missing or stalled lane blocks
// every younger lane. Also reports how many lanes were granted.
module dq_lane_select (
  input  logic [2:0] cand,
  input  logic [2:0] stall,
  output logic [2:0] grant,
  output logic [1:0] deq
);

  logic g2, g1, g0;

  assign g2 = cand[2] & ~stall[2];
  assign g1 = g2 & cand[1] & ~stall[1];
  assign g0 = g1 & cand[0] & ~stall[0];

  assign grant = {g2, g1, g0};
  assign deq   = 2'(g2) + 2'(g1) + 2'(g0);

endmodule

// File: rtl/dispatch_queue.sv
// 3-wide in-order dispatch queue between decode/rename and the reservation
// station; circular buffer with registered occupancy driving decode stalls.
module dispatch_queue
  import sys_defs::*;
#(
  parameter int DEPTH = `DQ_DEPTH,
  parameter int WAYS  = SYS_WAYS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  RS_IN_PACKET [WAYS-1:0]     dec_in,
  output logic [WAYS-1:0]            dec_stall,
  input  logic                       flush,
  output RS_IN_PACKET [WAYS-1:0]     rs_in,
  input  logic [WAYS-1:0]            struct_stall,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  RS_IN_PACKET    entries [DEPTH];
  logic [IW-1:0]  head, tail;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  free;
  logic [2:0]     cand, issue, accept, in_valid;
  logic [1:0]     deq, enq;
  logic [IW-1:0]  rd_idx [3];
  logic [IW-1:0]  wr_idx [3];

  assign count = cnt;
  assign free  = CW'(DEPTH) - cnt;

  // Stall is based on registered occupancy only, so slots freed by this
  // cycle's dequeue are not offered to decode until next cycle.
  always_comb begin
    if (!reset) begin
      dec_stall = 3'b111;
    end else begin
      dec_stall = {free < CW'(1), free < CW'(2), free < CW'(3)};
    end
  end

  always_comb begin
    for (int l = 0; l < 3; l++) begin
      in_valid[l] = dec_in[l].valid;
    end
    accept = in_valid & ~dec_stall;
    enq    = 2'(accept[2]) + 2'(accept[1]) + 2'(accept[0]);
  end

  // Accepted lanes pack densely at tail in age order; skipped lanes use no slot.
  always_comb begin
    wr_idx[2] = tail;
    wr_idx[1] = tail + IW'(accept[2]);
    wr_idx[0] = tail + IW'(accept[2]) + IW'(accept[1]);
    rd_idx[2] = head;
    rd_idx[1] = head + IW'(1);
    rd_idx[0] = head + IW'(2);
  end

  assign cand = {cnt != '0, cnt >= CW'(2), cnt >= CW'(3)};

  dq_lane_select u_lane_select (
    .cand  (cand),
    .stall (struct_stall),
    .grant (issue),
    .deq   (deq)
  );

  always_comb begin
    for (int l = 0; l < 3; l++) begin
      rs_in[l] = issue[l] ? entries[rd_idx[l]] : '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      for (int l = 0; l < 3; l++) begin
        if (issue[l]) entries[rd_idx[l]].valid <= 1'b0;
      end
      for (int l = 0; l < 3; l++) begin
        if (accept[l]) entries[wr_idx[l]] <= dec_in[l];
      end
      head <= head + IW'(deq);
      tail <= tail + IW'(enq);
      cnt  <= cnt + CW'(enq) - CW'(deq);
    end
  end

  // Decode presenting a lane it was told to hold would silently lose it.
  no_drop_a: assert property (@(posedge clock) disable iff (!reset)
                              !(|(in_valid & dec_stall)));

endmodule
